// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for a shared ADD/SUB/AND/XOR ALU.
// Each accepted operation runs IDLE -> EXEC -> RESP and its result is held until consumed.
module alu_share_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_of,
  output logic             rsp_zf,
  output logic             rsp_sf,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;

  logic [1:0]       state;
  logic             last_grant;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;

  logic             grant_valid;
  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] y_next;
  logic             of_next;

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid)
      grant_id = ~last_grant;
    else if (req1_valid)
      grant_id = 1'b1;
  end

  assign accept     = (state == IDLE) && grant_valid;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  always_comb begin
    y_next  = '0;
    of_next = 1'b0;
    case (op_q)
      OP_ADD: begin
        y_next  = a_q + b_q;
        of_next = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (y_next[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        y_next  = a_q - b_q;
        of_next = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (y_next[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  y_next = a_q & b_q;
      default: y_next = a_q ^ b_q;
    endcase
  end

  // Reset drops any in-flight operation; response registers only change on EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_y      <= '0;
      rsp_of     <= 1'b0;
      rsp_zf     <= 1'b0;
      rsp_sf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= grant_id ? req1_op : req0_op;
            a_q        <= grant_id ? req1_a  : req0_a;
            b_q        <= grant_id ? req1_b  : req0_b;
            id_q       <= grant_id;
            last_grant <= grant_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_y  <= y_next;
          rsp_of <= of_next;
          rsp_zf <= (y_next == '0);
          rsp_sf <= y_next[WIDTH-1];
          rsp_id <= id_q;
          state  <= RESP;
        end
        RESP: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: the driver queues hand-computed responses,
// a negedge monitor pops and compares them on every response handshake.
module tb_alu_share_arbiter;

  localparam logic [1:0] ADD = 2'd0;
  localparam logic [1:0] SUB = 2'd1;
  localparam logic [1:0] AND = 2'd2;
  localparam logic [1:0] XOR = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = '0, req1_op = '0;
  logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_of, rsp_zf, rsp_sf, busy;
  logic [63:0] rsp_y;

  typedef struct packed {
    logic        id;
    logic [63:0] y;
    logic        of;
    logic        zf;
    logic        sf;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   passCount = 0;
  int   totalCount = 0;
  int   cycle = 0;
  int   acceptCycle = -100;
  int   bothReadyCount = 0;
  logic prevValid = 1'b0;
  int   who;

  alu_share_arbiter #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .rsp_of(rsp_of), .rsp_zf(rsp_zf), .rsp_sf(rsp_sf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: handshake-driven scoreboard compare plus latency and ready-exclusivity tracking.
  always @(negedge clk) begin
    if (rst) begin
      prevValid = 1'b0;
    end else begin
      if (req0_ready && req1_ready) bothReadyCount++;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acceptCycle = cycle;
      if (rsp_valid && !prevValid) checkOutput("latency", 64'(cycle - acceptCycle), 64'd2);
      if (rsp_valid && rsp_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("rsp_id", {63'd0, rsp_id}, {63'd0, monExp.id});
          checkOutput("rsp_y", rsp_y, monExp.y);
          checkOutput("rsp_of", {63'd0, rsp_of}, {63'd0, monExp.of});
          checkOutput("rsp_zf", {63'd0, rsp_zf}, {63'd0, monExp.zf});
          checkOutput("rsp_sf", {63'd0, rsp_sf}, {63'd0, monExp.sf});
        end
      end
      prevValid = rsp_valid;
    end
  end

  task automatic applyStimulus(input int n, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] ey, input logic eof, input logic ezf, input logic esf,
                               input logic push);
    exp_t e;
    if (n == 0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
    e.id = (n != 0);
    e.y  = ey;
    e.of = eof;
    e.zf = ezf;
    e.sf = esf;
    if (push) expQ.push_back(e);
  endtask

  // Returns just after the accept edge; who = accepted requester (-1 on timeout).
  task automatic waitAnyAccept(output int acc);
    acc = -1;
    for (int i = 0; i < 60 && acc < 0; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) acc = 0;
      else if (req1_valid && req1_ready) acc = 1;
    end
    if (acc < 0) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40 && expQ.size() != 0; i++) @(posedge clk);
    #1;
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_valid"}, {63'd0, rsp_valid}, 64'd0);
    checkOutput({tag, "_y"}, rsp_y, 64'd0);
    checkOutput({tag, "_flags"}, {60'd0, rsp_id, rsp_of, rsp_zf, rsp_sf}, 64'd0);
    checkOutput({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    // Reset with both requesters valid: req0 must win the first tie.
    applyStimulus(0, ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1, SUB, 64'd5, 64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkCleared("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("first_req0_ready", {63'd0, req0_ready}, 64'd1);
    checkOutput("first_req1_ready", {63'd0, req1_ready}, 64'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    waitAnyAccept(who);
    checkOutput("second_grant", 64'(who), 64'd1);
    req1_valid = 1'b0;

    applyStimulus(0, AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                  64'hF000_F000_F000_F000, 1'b0, 1'b0, 1'b1, 1'b1);
    waitAnyAccept(who);
    req0_valid = 1'b0;
    waitDrain();

    // Backpressure: response held 10 cycles while req0 waits.
    rsp_ready = 1'b0;
    applyStimulus(1, XOR, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 1'b1, 1'b1);
    waitAnyAccept(who);
    req1_valid = 1'b0;
    applyStimulus(0, SUB, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", {63'd0, rsp_valid}, 64'd1);
      checkOutput("stall_y", rsp_y, 64'hFEDC_BA98_7654_3210);
      checkOutput("stall_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
      checkOutput("stall_busy", {63'd0, busy}, 64'd1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("release_busy", {63'd0, busy}, 64'd0);
    checkOutput("release_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("release_req0_ready", {63'd0, req0_ready}, 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    waitDrain();

    // Reset during EXEC drops the operation and clears the held response.
    applyStimulus(0, ADD, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    waitAnyAccept(who);
    req0_valid = 1'b0;
    #1 rst = 1'b1;
    #1 checkCleared("midreset");

    // Both requesters valid continuously for four ops: grants 0,1,0,1.
    applyStimulus(0, XOR, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0,
                  64'hF0F0_F0F0_F0F0_F0F0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1, ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                  64'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      waitAnyAccept(who);
      checkOutput("rr_grant", 64'(who), 64'(k % 2));
      if (k == 0)
        applyStimulus(0, SUB, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
      else if (k == 1)
        applyStimulus(1, SUB, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1);
      else if (who == 0)
        req0_valid = 1'b0;
      else
        req1_valid = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    waitDrain();
    repeat (3) @(posedge clk);

    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
    checkOutput("ready_exclusive", 64'(bothReadyCount), 64'd0);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
